mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency memory between the instruction-fetch stage and the data-access (MEM) stage of the 5-stage pipeline. It arbitrates between the two requesters, sequences each access with a small FSM and a latency counter, and returns read data with a one-cycle acknowledge. While any request is outstanding it drives a pipeline-wide stall, which lets the CPU move from split instruction/data memories to a unified memory.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single fixed-latency memory port between instruction fetch and data access.
// Build option MEM_ARB_RR_EN selects round-robin tie-breaking; default is data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant_q, grant_d;           // 1 = data port owns the access
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              pick_dm;

`ifdef MEM_ARB_RR_EN
  assign pick_dm = dm_req_i & (~if_req_i | ~last_grant_q);
`else
  // last_grant is still tracked here, but fixed priority ignores it.
  assign pick_dm = dm_req_i | (1'b0 & last_grant_q);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_data_q    <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_data_q    <= if_data_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_data_d    = if_data_q;
    dm_rdata_d   = dm_rdata_q;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if_ack_o     = 1'b0;
    dm_ack_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (if_req_i || dm_req_i)) begin
          grant_d = pick_dm;
          addr_d  = pick_dm ? dm_addr_i : if_addr_i;
          we_d    = pick_dm & dm_we_i;
          wdata_d = pick_dm ? dm_wdata_i : '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        cnt_d       = 4'(MEM_LAT);
        state_d     = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Read data is only valid in the last WAIT cycle.
        if (cnt_q == 4'd1) begin
          if (!we_q) begin
            if (grant_q) dm_rdata_d = mem_rdata_i;
            else         if_data_d  = mem_rdata_i;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if_ack_o     = ~grant_q;
        dm_ack_o     = grant_q;
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_data_o  = if_data_q;
  assign dm_rdata_o = dm_rdata_q;
  assign stall_o    = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
// Honours MEM_ARB_RR_EN to match the round-robin build.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we, stall;
  logic [31:0] if_data, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req1;
  logic [31:0] if_addr1;
  logic        one1 = 1'b1, zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;
  logic        if_ack1, dm_ack1, mem_en1, mem_we1, stall1;
  logic [31:0] if_data1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk_i(clk), .rst_i(rst), .start_i(one1),
    .if_req_i(if_req1), .if_addr_i(if_addr1), .if_ack_o(if_ack1), .if_data_o(if_data1),
    .dm_req_i(zero1), .dm_we_i(zero1), .dm_addr_i(zero32), .dm_wdata_i(zero32),
    .dm_ack_o(dm_ack1), .dm_rdata_o(dm_rdata1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
    .mem_rdata_i(mem_rdata1), .stall_o(stall1)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B9) ^ 32'h5A5AA5A5);
  endfunction

  function automatic logic [31:0] rand_addr();
    return {22'd0, 4'd0, 4'($urandom_range(15)), 2'b00};
  endfunction

  // Memory device: read data is presented only in the single valid cycle, garbage otherwise.
  logic [31:0] mem_dev [0:255];
  logic        mem_init;
  logic [31:0] rd_word, rd_word1;
  int          cd = 0, cd1 = 0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_dev[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      mem_dev[mem_addr[9:2]] <= mem_wdata;
    end
    if (mem_en) begin
      rd_word <= mem_dev[mem_addr[9:2]];
      cd      <= LAT;
    end else if (cd != 0) begin
      cd <= cd - 1;
    end
    if (mem_en1) begin
      rd_word1 <= mem_dev[mem_addr1[9:2]];
      cd1      <= 1;
    end else if (cd1 != 0) begin
      cd1 <= cd1 - 1;
    end
  end
  assign mem_rdata  = (cd == 1)  ? rd_word  : 32'hBADC0FFE;
  assign mem_rdata1 = (cd1 == 1) ? rd_word1 : 32'hBADC0FFE;

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          cyc, free_cyc, exp_issue, exp_ack;
  bit          g_dm, g_we, lg_dm, if_done, dm_done;
  logic [31:0] g_addr, g_wdata, g_val, exp_if_data, exp_dm_rdata;
  int          if_mode, dm_mode;
  int          n_pass, n_checks;
  int          last_if_ack, last_dm_ack, en_cnt;
  int          obs[$];
  bit          observe;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic drive_if();
    if (if_done) begin
      if_done = 1'b0;
      if_req  = (if_mode == 2) || ($urandom_range(1) == 1);
      if_addr = rand_addr();
    end else if (!if_req && $urandom_range(3) == 0) begin
      if_req  = 1'b1;
      if_addr = rand_addr();
    end
  endtask

  task automatic drive_dm();
    if (dm_done || (!dm_req && $urandom_range(3) == 0)) begin
      dm_req   = (dm_mode == 2) || !dm_done || ($urandom_range(1) == 1);
      dm_done  = 1'b0;
      dm_we    = $urandom_range(1) == 1;
      dm_addr  = rand_addr();
      dm_wdata = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (if_mode != 0) drive_if();
    if (dm_mode != 0) drive_dm();
  endtask

  task automatic eval();
    bit e_en, e_if_ack, e_dm_ack;
    int idx;
    #1;
    e_en     = (cyc == exp_issue);
    e_if_ack = (cyc == exp_ack) && !g_dm;
    e_dm_ack = (cyc == exp_ack) && g_dm;
    if (cyc == exp_ack) begin
      lg_dm = g_dm;
      if (!g_dm) begin
        exp_if_data = g_val;
        if_done     = 1'b1;
      end else begin
        if (!g_we) exp_dm_rdata = g_val;
        dm_done = 1'b1;
      end
    end
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_en & g_we);
    check("mem_addr", mem_addr, e_en ? g_addr : 32'd0);
    if (!e_en || g_we) check("mem_wdata", mem_wdata, e_en ? g_wdata : 32'd0);
    check("if_ack", if_ack, e_if_ack);
    check("dm_ack", dm_ack, e_dm_ack);
    check("stall", stall, (if_req & ~e_if_ack) | (dm_req & ~e_dm_ack));
    check("if_data", if_data, exp_if_data);
    check("dm_rdata", dm_rdata, exp_dm_rdata);
    if (mem_en) en_cnt++;
    if (if_ack) begin last_if_ack = cyc; if (observe) obs.push_back(0); end
    if (dm_ack) begin last_dm_ack = cyc; if (observe) obs.push_back(1); end
    if (rst) begin
      exp_issue = -1; exp_ack = -1; free_cyc = cyc + 1;
      exp_if_data = '0; exp_dm_rdata = '0; lg_dm = 1'b0;
    end else if (cyc >= free_cyc && start && (if_req || dm_req)) begin
`ifdef MEM_ARB_RR_EN
      g_dm = dm_req && (!if_req || !lg_dm);
`else
      g_dm = dm_req;
`endif
      g_addr  = g_dm ? dm_addr : if_addr;
      g_we    = g_dm && dm_we;
      g_wdata = dm_wdata;
      idx     = int'(g_addr[9:2]);
      if (g_we) ref_mem[idx] = g_wdata;
      else      g_val = ref_mem[idx];
      exp_issue = cyc + 1;
      exp_ack   = cyc + 2 + LAT;
      free_cyc  = cyc + 3 + LAT;
    end
  endtask

  task automatic run_one(input bit is_dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int t, e0;
    tick();
    if (is_dm) begin dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    last_if_ack = -1; last_dm_ack = -1; e0 = en_cnt; t = cyc;
    eval();
    for (int k = 0; k < 40 && (is_dm ? last_dm_ack : last_if_ack) < 0; k++) begin
      tick(); eval();
    end
    check("txn_latency", (is_dm ? last_dm_ack : last_if_ack) - t, LAT + 2);
    check("txn_mem_en_count", en_cnt - e0, 1);
    tick(); if_req = 1'b0; dm_req = 1'b0; eval();
  endtask

  task automatic drain();
    last_if_ack = -1; last_dm_ack = -1;
    for (int k = 0; k < 80 && (if_req || dm_req); k++) begin
      tick();
      start = 1'b1;
      if (last_if_ack >= 0) if_req = 1'b0;
      if (last_dm_ack >= 0) dm_req = 1'b0;
      eval();
    end
    check("drain_done", {if_req, dm_req}, 2'b00);
    repeat (LAT + 4) begin tick(); eval(); end
  endtask

  initial begin
    int e0, t0;
    int tie_exp[3];
    rst = 1'b1; start = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; if_req1 = 1'b0; if_addr1 = '0;
    mem_init = 1'b1; if_mode = 0; dm_mode = 0; observe = 1'b0;
    cyc = 0; n_pass = 0; n_checks = 0; en_cnt = 0;
    exp_issue = -1; exp_ack = -1; free_cyc = 0; lg_dm = 1'b0;
    g_dm = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; g_val = '0;
    exp_if_data = '0; exp_dm_rdata = '0; if_done = 1'b0; dm_done = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    tick(); mem_init = 1'b0; eval();
    tick(); rst = 1'b0; eval();
    check("reset_if_data", if_data, 32'd0);
    check("reset_dm_rdata", dm_rdata, 32'd0);
    check("reset_mem_en", mem_en, 1'b0);

    // MEM_LAT = 1 instance: back-to-back fetches with req held through each ack
    for (int j = 0; j < 14; j++) begin
      tick();
      if_req1  = (j < 12);
      if_addr1 = 32'h40 + 32'(4 * (j / 4));
      eval();
      check("lat1_ack", if_ack1, (j < 12) && (j % 4 == 3));
      if (j < 12 && j % 4 == 3) check("lat1_data", if_data1, ref_mem[16 + j / 4]);
    end

    run_one(1'b1, 1'b1, 32'h20, 32'h12345678);
    check("store_keeps_rdata", dm_rdata, 32'd0);
    run_one(1'b1, 1'b0, 32'h20, 32'h0);
    check("load_after_store", dm_rdata, 32'h12345678);
    run_one(1'b0, 1'b0, 32'h10, 32'h0);
    check("fetch_word", if_data, 32'hDEADBEEF);

    // Both requesters held for three transactions
`ifdef MEM_ARB_RR_EN
    tie_exp = '{1, 0, 1};
`else
    tie_exp = '{1, 1, 1};
`endif
    obs.delete(); observe = 1'b1; if_done = 1'b0; dm_done = 1'b0;
    tick();
    if_req = 1'b1; if_addr = rand_addr();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = rand_addr();
    if_mode = 2; dm_mode = 2;
    eval();
    for (int k = 0; k < 60 && obs.size() < 3; k++) begin tick(); eval(); end
    observe = 1'b0; if_mode = 0; dm_mode = 0;
    tick(); if_req = 1'b0; dm_req = 1'b0; eval();
    check("tie_count", obs.size(), 3);
    for (int k = 0; k < 3 && k < obs.size(); k++) check("tie_winner", obs[k], tie_exp[k]);
    repeat (LAT + 4) begin tick(); eval(); end

    // start_i low blocks new grants; data wins once it rises
    run_one(1'b0, 1'b0, rand_addr(), 32'h0);
    tick();
    start = 1'b0; if_req = 1'b1; if_addr = rand_addr();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = rand_addr();
    e0 = en_cnt;
    eval();
    repeat (5) begin tick(); eval(); end
    check("nostart_mem_en", en_cnt - e0, 0);
    check("nostart_stall", stall, 1'b1);
    obs.delete(); observe = 1'b1;
    drain();
    observe = 1'b0;
    check("start_first_winner", obs.size() > 0 ? obs[0] : -1, 1);

    // Reset during WAIT aborts the access
    tick(); if_req = 1'b1; if_addr = rand_addr(); eval();
    tick(); eval();
    tick(); eval();
    tick(); rst = 1'b1; if_req = 1'b0; eval();
    last_if_ack = -1; e0 = en_cnt;
    tick(); rst = 1'b0; eval();
    repeat (5) begin tick(); eval(); end
    check("reset_no_ack", last_if_ack, -1);
    check("reset_no_mem_en", en_cnt - e0, 0);
    run_one(1'b0, 1'b0, rand_addr(), 32'h0);

    // Randomized traffic
    if_done = 1'b0; dm_done = 1'b0; if_mode = 3; dm_mode = 3;
    for (int k = 0; k < 600; k++) begin
      tick();
      if ($urandom_range(9) == 0) start = ~start;
      eval();
    end
    if_mode = 0; dm_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
